serial_rx_deframer: RTL and testbench

RS232 receive deframer on the upstream side of the serial echo path. It oversamples the asynchronous `rx` line at the system clock, detects a start bit, and samples 8 data bits LSB-first, an optional even-parity bit and one stop bit at mid-bit. It delivers the byte with parity and framing status through a one-entry valid/ready output register to the echo/increment stage.

---
 rtl/serial_defs_pkg.sv | 22 ++
 rtl/serial_line_sync.sv | 28 ++
 rtl/serial_rx_deframer.sv | 202 ++++++++++++++++++++
 tb/tb_serial_rx_deframer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_defs_pkg.sv
// serial_defs: definitions shared by the serial receive and transmit paths.
//   - rx_state_e : receive-deframer FSM state encodings
//   - CLK_FREQ_DEF / BAUD_DEF : default system clock and line rate
//   - DATA_BITS, FRAME_BITS_PAR, FRAME_BITS_NOPAR : frame-length constants
package serial_defs;

  localparam int unsigned CLK_FREQ_DEF     = 50_000_000;
  localparam int unsigned BAUD_DEF         = 115_200;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned FRAME_BITS_PAR   = 11;  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS_NOPAR = 10;  // start + 8 data + stop

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/serial_line_sync.sv
// serial_line_sync: 2-flop synchroniser for an asynchronous serial line plus
// a third flop for falling-edge detection. All flops reset to 1 (idle line).
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   rx_i      in  asynchronous serial line
//   rx_sync_o out synchronised line level
//   rx_fall_o out one-cycle pulse on a synchronised 1->0 transition
module serial_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic rx_fall_o
);

  // [0],[1] synchroniser stages, [2] previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 3'b111;
    else      sync_q <= {sync_q[1:0], rx_i};
  end

  assign rx_sync_o = sync_q[1];
  assign rx_fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer: RS232 receive deframer. Detects a start bit on the
// oversampled line, samples 8 data bits LSB-first, an optional even-parity
// bit and one stop bit at mid-bit, and presents the byte with its status
// through a one-entry valid/ready output register.
// Build option: define SERIAL_RX_PARITY_EN for an 11-bit frame with even
// parity; otherwise a 10-bit frame is received and parity_err is tied to 0.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   rx         in  asynchronous serial input, idles high
//   data       out received byte, stable while data_valid
//   data_valid out byte available, held until accepted
//   data_ready in  consumer accept (data_valid && data_ready on a rising edge)
//   parity_err out received parity differs from even parity of data
//   frame_err  out stop bit sampled 0
//   overrun    out one-cycle pulse when a completed byte is dropped
//
// state        | meaning
// ST_IDLE      | waiting for a synchronised falling edge
// ST_START     | timing to mid start bit, rejecting glitches
// ST_DATA      | sampling data bits 0..7
// ST_PARITY    | sampling the parity bit (parity builds only)
// ST_STOP      | sampling the stop bit; frame completes here
// ST_WAIT_IDLE | stop bit was 0, waiting for the line to return high
module serial_rx_deframer
  import serial_defs::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD      = BAUD_DEF,
  parameter int unsigned BIT_TICKS = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_sync, rx_fall;

  serial_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx),
    .rx_sync_o (rx_sync),
    .rx_fall_o (rx_fall)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          done, ferr_now;
`ifdef SERIAL_RX_PARITY_EN
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    done     = 1'b0;
    ferr_now = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (tick_q == HALF_LAST) begin
          tick_d = '0;
          if (rx_sync) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d         = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q == BIT_LAST) begin
          tick_d  = '0;
          perr_d  = ^{shift_q, rx_sync};
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_q == BIT_LAST) begin
          tick_d = '0;
          done   = 1'b1;
          if (rx_sync) begin
            state_d = ST_IDLE;
          end else begin
            ferr_now = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must not restart a frame until it idles.
        tick_d = '0;
        if (rx_sync) state_d = ST_IDLE;
      end
      default: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [7:0] data_q;
  logic       valid_q, perr_out_q, ferr_out_q, overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done) begin
        // Accept in the same cycle frees the slot for the new byte.
        if (!valid_q || data_ready) begin
          data_q     <= shift_q;
          valid_q    <= 1'b1;
          ferr_out_q <= ferr_now;
`ifdef SERIAL_RX_PARITY_EN
          perr_out_q <= perr_q;
`else
          perr_out_q <= 1'b0;
`endif
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb_serial_rx_deframer: directed bench for serial_rx_deframer at the default
// 434 clocks per bit. Builds with or without SERIAL_RX_PARITY_EN.
module tb_serial_rx_deframer;

  localparam int BT = 434;
`ifdef SERIAL_RX_PARITY_EN
  localparam int LAT      = 4560;  // start-bit drive to data_valid seen
  localparam int EXP_PBAD = 1;
`else
  localparam int LAT      = 4126;
  localparam int EXP_PBAD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  serial_rx_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int ov_cnt   = 0;
  int start_cyc;
  int base_rise, base_ov;
  logic dv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dv_prev <= data_valid;
    if (data_valid && !dv_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; holds the level for one bit period.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk(tag, data_valid, 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // clean 0x53
    base_rise = rise_cnt;
    send_frame(8'h53, 1'b0, 1'b1);
    chk("s1_valid", data_valid, 1'b1);
    chk("s1_data", data, 8'h53);
    chk("s1_perr", parity_err, 1'b0);
    chk("s1_ferr", frame_err, 1'b0);
    chk("s1_latency", rise_cyc - start_cyc, LAT);
    chk("s1_count", rise_cnt - base_rise, 1);
    consume("s1_consume");

    // wrong parity bit
    send_frame(8'h53, 1'b1, 1'b1);
    chk("s2_data", data, 8'h53);
    chk("s2_perr", parity_err, EXP_PBAD);
    chk("s2_ferr", frame_err, 1'b0);
    consume("s2_consume");

    // stop bit 0, line held low (break), then a clean 0xA5
    base_rise = rise_cnt;
    send_frame(8'h53, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    chk("s3_count", rise_cnt - base_rise, 1);
    chk("s3_data", data, 8'h53);
    chk("s3_ferr", frame_err, 1'b1);
    chk("s3_perr", parity_err, 1'b0);
    consume("s3_consume");
    repeat (BT) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("s3b_valid", data_valid, 1'b1);
    chk("s3b_data", data, 8'hA5);
    chk("s3b_ferr", frame_err, 1'b0);
    chk("s3b_perr", parity_err, 1'b0);
    consume("s3b_consume");

    // 100-clock glitch
    base_rise = rise_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    chk("s4_count", rise_cnt - base_rise, 0);
    chk("s4_valid", data_valid, 1'b0);

    // two back-to-back frames without accept
    base_rise = rise_cnt;
    base_ov = ov_cnt;
    send_frame(8'h53, 1'b0, 1'b1);
    send_frame(8'h54, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("s5_data", data, 8'h53);
    chk("s5_valid", data_valid, 1'b1);
    chk("s5_ovr", ov_cnt - base_ov, 1);
    chk("s5_count", rise_cnt - base_rise, 1);
    consume("s5_consume");

    // reset during bit 4 with a byte pending
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("s6_pending", data_valid, 1'b1);
    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (BT / 2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("s6_rst_data", data, 8'h00);
    chk("s6_rst_valid", data_valid, 1'b0);
    chk("s6_rst_perr", parity_err, 1'b0);
    chk("s6_rst_ferr", frame_err, 1'b0);
    chk("s6_rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    base_rise = rise_cnt;
    repeat (2000) @(negedge clk);
    chk("s6_no_byte", rise_cnt - base_rise, 0);
    send_frame(8'h53, 1'b0, 1'b1);
    chk("s6_valid", data_valid, 1'b1);
    chk("s6_data", data, 8'h53);
    chk("s6_perr", parity_err, 1'b0);
    chk("s6_ferr", frame_err, 1'b0);
    consume("s6_consume");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
